// File: rtl/proc_cmd_sequencer.sv
// Command sequencer for the Processor control port.
// Each accepted command expands into the registered enable/address sequence
// that the Processor expects. When the command finishes, done pulses for one
// cycle, and err rides with done when the opcode was illegal.
module proc_cmd_sequencer #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned EXEC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_rd,
  input  logic [1:0]  cmd_ra,
  input  logic [1:0]  cmd_rb,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        done,
  output logic        err,
  output logic [31:0] rsp_data,
  output logic        reg_write_enable,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [1:0]  reg_address1,
  output logic [1:0]  reg_address2,
  output logic [1:0]  alu_op,
  output logic [8:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WMEM,
    S_RD,
    S_RWB,
    S_EXEC,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    OP_WMEM = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_MUL  = 3'b011,
    OP_RMEM = 3'b100
  } op_e;

  localparam logic [3:0] RD_CNT   = 4'(RD_LAT - 1);
  localparam logic [3:0] EXEC_CNT = 4'(EXEC_LAT - 1);

  // FSM state, latency counter and latched command fields
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  ra_q, ra_d;
  logic [1:0]  rb_q, rb_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  // Registered outputs
  logic        rwe_q, rwe_d;
  logic        mwe_q, mwe_d;
  logic        mre_q, mre_d;
  logic [1:0]  ra1_q, ra1_d;
  logic [1:0]  ra2_q, ra2_d;
  logic [1:0]  alu_q, alu_d;
  logic [8:0]  maddr_q, maddr_d;
  logic [31:0] mdin_q, mdin_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rsp_q, rsp_d;

  logic        accept;
  logic        legal_op;

  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign cmd_ready = (state_q == S_IDLE) && reset;

  assign reg_write_enable = rwe_q;
  assign mem_write_enable = mwe_q;
  assign mem_read_enable  = mre_q;
  assign reg_address1     = ra1_q;
  assign reg_address2     = ra2_q;
  assign alu_op           = alu_q;
  assign mem_address      = maddr_q;
  assign mem_data_in      = mdin_q;
  assign done             = done_q;
  assign err              = err_q;
  assign rsp_data         = rsp_q;

  // State register: FSM, counter, command fields and all outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rwe_q   <= 1'b0;
      mwe_q   <= 1'b0;
      mre_q   <= 1'b0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      alu_q   <= '0;
      maddr_q <= '0;
      mdin_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rwe_q   <= rwe_d;
      mwe_q   <= mwe_d;
      mre_q   <= mre_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      alu_q   <= alu_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
    end
  end

  // Next state: latch fields on accept, step through phases using the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    addr_d  = addr_q;
    data_d  = data_q;

    legal_op = 1'b0;
    case (cmd_op)
      OP_WMEM, OP_LOAD, OP_ADD, OP_MUL, OP_RMEM: legal_op = 1'b1;
      default:                                   legal_op = 1'b0;
    endcase

    if (accept) begin
      op_d   = cmd_op;
      rd_d   = cmd_rd;
      ra_d   = cmd_ra;
      rb_d   = cmd_rb;
      addr_d = cmd_addr;
      data_d = cmd_data;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WMEM: state_d = S_WMEM;
            OP_LOAD, OP_RMEM: begin
              state_d = S_RD;
              cnt_d   = RD_CNT;
            end
            OP_ADD, OP_MUL: begin
              state_d = S_EXEC;
              cnt_d   = EXEC_CNT;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WMEM: state_d = S_IDLE;
      S_RD: begin
        if (cnt_q == '0) begin
          state_d = (op_q == OP_LOAD) ? S_RWB : S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RWB: state_d = S_IDLE;
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every Processor-facing signal is registered
  always_comb begin
    rwe_d   = 1'b0;
    mwe_d   = 1'b0;
    mre_d   = 1'b0;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    alu_d   = alu_q;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;

    done_d = ((state_q != S_IDLE) && (state_d == S_IDLE)) || (accept && !legal_op);
    err_d  = accept && !legal_op;
    rsp_d  = ((state_q == S_RD) && (cnt_q == '0) && (op_q == OP_RMEM)) ? mem_data_out : rsp_q;

    case (state_d)
      S_WMEM: begin
        mwe_d   = 1'b1;
        maddr_d = addr_d;
        mdin_d  = data_d;
      end
      S_RD: begin
        mre_d   = 1'b1;
        maddr_d = addr_d;
      end
      S_RWB: begin
        mre_d = 1'b1;
        rwe_d = 1'b1;
        ra1_d = rd_d;
      end
      S_EXEC: begin
        ra1_d = ra_d;
        ra2_d = rb_d;
        alu_d = (op_d == OP_MUL) ? 2'b01 : 2'b00;
      end
      S_WB: begin
        rwe_d = 1'b1;
        ra1_d = rd_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_cmd_sequencer.sv
// Testbench for proc_cmd_sequencer.
// The bench builds two builds of the sequencer (RD_LAT/EXEC_LAT = 1/1 and 3/2).
// A queue-based model expands each accepted command into its per-cycle output trace.
module tb_proc_cmd_sequencer;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        err;
    logic        rwe;
    logic        mwe;
    logic        mre;
    logic [1:0]  ra1;
    logic [1:0]  ra2;
    logic [1:0]  alu;
    logic [8:0]  maddr;
    logic [31:0] mdin;
    logic [31:0] rsp;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [1:0]  cmd_rd = '0;
  logic [1:0]  cmd_ra = '0;
  logic [1:0]  cmd_rb = '0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] mem_data_out;
  logic        sel = 1'b0;

  logic        a_ready, a_done, a_err, a_rwe, a_mwe, a_mre;
  logic [1:0]  a_ra1, a_ra2, a_alu;
  logic [8:0]  a_maddr;
  logic [31:0] a_mdin, a_rsp;
  logic        b_ready, b_done, b_err, b_rwe, b_mwe, b_mre;
  logic [1:0]  b_ra1, b_ra2, b_alu;
  logic [8:0]  b_maddr;
  logic [31:0] b_mdin, b_rsp;

  obs_t obs_a, obs_b, obs, cur;

  int n_checks = 0;
  int n_err = 0;
  int rd_lat = 1;
  int exec_lat = 1;

  proc_cmd_sequencer #(.RD_LAT(1), .EXEC_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(a_done), .err(a_err),
    .rsp_data(a_rsp), .reg_write_enable(a_rwe), .mem_write_enable(a_mwe),
    .mem_read_enable(a_mre), .reg_address1(a_ra1), .reg_address2(a_ra2),
    .alu_op(a_alu), .mem_address(a_maddr), .mem_data_in(a_mdin),
    .mem_data_out(mem_data_out)
  );

  proc_cmd_sequencer #(.RD_LAT(3), .EXEC_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(b_done), .err(b_err),
    .rsp_data(b_rsp), .reg_write_enable(b_rwe), .mem_write_enable(b_mwe),
    .mem_read_enable(b_mre), .reg_address1(b_ra1), .reg_address2(b_ra2),
    .alu_op(b_alu), .mem_address(b_maddr), .mem_data_in(b_mdin),
    .mem_data_out(mem_data_out)
  );

  always_comb begin
    obs_a = {a_ready, a_done, a_err, a_rwe, a_mwe, a_mre, a_ra1, a_ra2, a_alu, a_maddr, a_mdin, a_rsp};
    obs_b = {b_ready, b_done, b_err, b_rwe, b_mwe, b_mre, b_ra1, b_ra2, b_alu, b_maddr, b_mdin, b_rsp};
    obs   = sel ? obs_b : obs_a;
  end

  // Simple stand-in for the Processor's data memory, driven by the selected build
  logic [31:0] mem [512];
  assign mem_data_out = mem[obs.maddr];
  always @(posedge clk) begin
    if (reset && obs.mwe) mem[obs.maddr] <= obs.mdin;
  end

  // Model: each accepted command becomes a list of expected output cycles, ending with its done cycle
  obs_t q[$];
  logic [31:0] mmem [512];
  logic in_rst = 1'b1;

  initial begin : model
    obs_t h;
    logic bad;
    cur = '0;
    forever begin
      @(posedge clk or reset);
      if (!reset) begin
        q.delete();
        cur = '0;
        in_rst = 1'b1;
      end else if (in_rst) begin
        cur.ready = 1'b1;
        in_rst = 1'b0;
      end else begin
        if (cur.ready && cmd_valid) begin
          h = cur;
          h.ready = 1'b0; h.done = 1'b0; h.err = 1'b0;
          h.rwe = 1'b0; h.mwe = 1'b0; h.mre = 1'b0;
          bad = 1'b0;
          case (cmd_op)
            3'd0: begin
              h.mwe = 1'b1; h.maddr = cmd_addr; h.mdin = cmd_data;
              q.push_back(h);
              mmem[cmd_addr] = cmd_data;
            end
            3'd1, 3'd4: begin
              h.mre = 1'b1; h.maddr = cmd_addr;
              repeat (rd_lat) q.push_back(h);
              if (cmd_op == 3'd1) begin
                h.rwe = 1'b1; h.ra1 = cmd_rd;
                q.push_back(h);
              end else begin
                h.rsp = mmem[cmd_addr];
              end
            end
            3'd2, 3'd3: begin
              h.ra1 = cmd_ra; h.ra2 = cmd_rb;
              h.alu = (cmd_op == 3'd3) ? 2'd1 : 2'd0;
              repeat (exec_lat) q.push_back(h);
              h.rwe = 1'b1; h.ra1 = cmd_rd;
              q.push_back(h);
            end
            default: bad = 1'b1;
          endcase
          h.rwe = 1'b0; h.mwe = 1'b0; h.mre = 1'b0;
          h.ready = 1'b1; h.done = 1'b1; h.err = bad;
          q.push_back(h);
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else begin
          cur.done = 1'b0; cur.err = 1'b0; cur.ready = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of the selected build against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      n_checks++;
      if (obs !== cur) begin
        n_err++;
        $display("FAIL cycle t=%0t got{rdy=%b dn=%b er=%b rwe=%b mwe=%b mre=%b ra1=%0d ra2=%0d alu=%0d ma=%h md=%h rsp=%h} exp{rdy=%b dn=%b er=%b rwe=%b mwe=%b mre=%b ra1=%0d ra2=%0d alu=%0d ma=%h md=%h rsp=%h}",
                 $time, obs.ready, obs.done, obs.err, obs.rwe, obs.mwe, obs.mre, obs.ra1, obs.ra2, obs.alu, obs.maddr, obs.mdin, obs.rsp,
                 cur.ready, cur.done, cur.err, cur.rwe, cur.mwe, cur.mre, cur.ra1, cur.ra2, cur.alu, cur.maddr, cur.mdin, cur.rsp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present a command and return at the negedge of its first control cycle
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [8:0] addr, input logic [31:0] data,
                      output int wt);
    wt = 0;
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_addr = addr; cmd_data = data;
    cmd_valid = 1'b1;
    while (!obs.ready && wt < 64) begin
      @(negedge clk);
      wt++;
    end
    if (wt >= 64) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout got=busy exp=ready");
    end
    @(negedge clk);
  endtask

  // Drop valid and scramble the fields; the sequencer must ignore them
  task automatic release_cmd();
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 2'($urandom); cmd_ra = 2'($urandom);
    cmd_rb = 2'($urandom); cmd_addr = 9'($urandom); cmd_data = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!obs.done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 64) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout got=no_done exp=done");
    end
  endtask

  initial begin : stim
    int wt, cyc;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_all_zero", 32'(obs == '0), 32'd1);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(obs.ready), 32'd1);

    // WMEM x2
    send(3'd0, 2'd0, 2'd0, 2'd0, 9'h001, 32'h0000000a, wt);
    chk("wmem1_we", 32'(obs.mwe), 32'd1);
    chk("wmem1_addr", 32'(obs.maddr), 32'h001);
    chk("wmem1_data", obs.mdin, 32'h0000000a);
    release_cmd();
    wait_done(cyc);
    chk("wmem1_done_lat", cyc, 1);
    chk("wmem1_err", 32'(obs.err), 32'd0);
    send(3'd0, 2'd0, 2'd0, 2'd0, 9'h005, 32'h00000005, wt);
    chk("wmem2_addr", 32'(obs.maddr), 32'h005);
    chk("wmem2_data", obs.mdin, 32'h00000005);
    release_cmd();
    wait_done(cyc);

    // LOAD rd=0 addr=1
    send(3'd1, 2'd0, 2'd0, 2'd0, 9'h001, 32'h0, wt);
    release_cmd();
    chk("load_c1_re", 32'(obs.mre), 32'd1);
    chk("load_c1_rwe", 32'(obs.rwe), 32'd0);
    @(negedge clk);
    chk("load_c2_rwe", 32'(obs.rwe), 32'd1);
    chk("load_c2_re", 32'(obs.mre), 32'd1);
    chk("load_c2_ra1", 32'(obs.ra1), 32'd0);
    wait_done(cyc);
    chk("load_done_lat", cyc, 1);

    // RMEM addr=1
    send(3'd4, 2'd0, 2'd0, 2'd0, 9'h001, 32'h0, wt);
    release_cmd();
    wait_done(cyc);
    chk("rmem_lat", cyc, 1);
    chk("rmem_rsp", obs.rsp, 32'h0000000a);

    // ADD then MUL back-to-back with valid held
    send(3'd2, 2'd3, 2'd0, 2'd1, 9'h0, 32'h0, wt);
    chk("add_alu", 32'(obs.alu), 32'd0);
    chk("add_ra2", 32'(obs.ra2), 32'd1);
    send(3'd3, 2'd3, 2'd2, 2'd3, 9'h0, 32'h0, wt);
    chk("b2b_wait", wt, 2);
    chk("mul_alu", 32'(obs.alu), 32'd1);
    chk("mul_ra1", 32'(obs.ra1), 32'd2);
    release_cmd();
    @(negedge clk);
    chk("mul_wb_ra1", 32'(obs.ra1), 32'd3);
    wait_done(cyc);

    // Illegal op, then a valid ADD
    send(3'd7, 2'd1, 2'd1, 2'd1, 9'h0, 32'h0, wt);
    chk("ill_done", 32'(obs.done), 32'd1);
    chk("ill_err", 32'(obs.err), 32'd1);
    chk("ill_enables", 32'({obs.rwe, obs.mwe, obs.mre}), 32'd0);
    send(3'd2, 2'd2, 2'd1, 2'd1, 9'h0, 32'h0, wt);
    release_cmd();
    wait_done(cyc);
    chk("add_after_ill_err", 32'(obs.err), 32'd0);

    // Switch to the RD_LAT=3 / EXEC_LAT=2 build
    #2 reset = 1'b0;
    sel = 1'b1; rd_lat = 3; exec_lat = 2;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    send(3'd0, 2'd0, 2'd0, 2'd0, 9'h009, 32'h00001234, wt);
    release_cmd();
    wait_done(cyc);
    send(3'd1, 2'd2, 2'd0, 2'd0, 9'h009, 32'h0, wt);
    release_cmd();
    wait_done(cyc);
    chk("lat3_load_cycles", cyc, 4);
    send(3'd2, 2'd1, 2'd2, 2'd3, 9'h0, 32'h0, wt);
    release_cmd();
    wait_done(cyc);
    chk("lat2_add_cycles", cyc, 3);
    send(3'd4, 2'd0, 2'd0, 2'd0, 9'h009, 32'h0, wt);
    release_cmd();
    wait_done(cyc);
    chk("lat3_rmem_rsp", obs.rsp, 32'h00001234);

    // Reset asserted during EXEC of MUL
    send(3'd3, 2'd0, 2'd1, 2'd2, 9'h0, 32'h0, wt);
    release_cmd();
    #2 reset = 1'b0;
    #1 chk("async_reset_zero", 32'(obs == '0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 32'(obs.ready), 32'd1);
    chk("no_done_after_midreset", 32'(obs.done), 32'd0);
    send(3'd0, 2'd0, 2'd0, 2'd0, 9'h003, 32'h00000077, wt);
    chk("post_reset_wmem_addr", 32'(obs.maddr), 32'h003);
    chk("post_reset_wmem_we", 32'(obs.mwe), 32'd1);
    release_cmd();
    wait_done(cyc);
    chk("post_reset_wmem_lat", cyc, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/proc_cmd_sequencer.md
Name: proc_cmd_sequencer

Overview:
- Command-driven initiator for the Processor control port (clk, reset, reg/mem enables, register addresses, alu_op, mem_address, mem_data_in/out).
- Accepts one high-level command per valid/ready handshake and expands it into the cycle-accurate enable/address sequence the Processor expects.
- Sits between a host or test controller and the Processor, replacing hand-sequenced control waveforms.

Parameters:
- RD_LAT, 1, cycles mem_read_enable/mem_address are held before mem_data_out is valid; legal 1..15.
- EXEC_LAT, 1, cycles ALU operands/alu_op are held before write-back; legal 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  000 WMEM, 001 LOAD, 010 ADD, 011 MUL, 100 RMEM, others illegal.
- cmd_rd  input  2  destination register.
- cmd_ra  input  2  operand A register.
- cmd_rb  input  2  operand B register.
- cmd_addr  input  9  memory word address.
- cmd_data  input  32  WMEM write data.
- done  output  1  one-cycle completion pulse.
- err  output  1  high with done when the command was illegal.
- rsp_data  output  32  RMEM captured word.
- reg_write_enable  output  1  to Processor.
- mem_write_enable  output  1  to Processor.
- mem_read_enable  output  1  to Processor.
- reg_address1  output  2  to Processor.
- reg_address2  output  2  to Processor.
- alu_op  output  2  to Processor; 00 add, 01 mul.
- mem_address  output  9  to Processor.
- mem_data_in  output  32  to Processor.
- mem_data_out  input  32  from Processor.

Behaviour:
- Reset values:
  - All outputs are 0, including rsp_data, done and err.
  - State is IDLE. cmd_ready is 1 once reset deasserts.
- Registered outputs: all Processor-facing outputs are registered. The first control cycle is the cycle after the accepting edge.
- Handshake:
  - cmd_ready = (state == IDLE). A command is accepted on a rising edge with cmd_valid && cmd_ready.
  - All cmd_* fields are latched at acceptance. Later changes on cmd_* are ignored.
- States: IDLE, WMEM, RD, RWB, EXEC, WB.
- IDLE:
  - All three enables are 0.
  - reg_address1/2, alu_op, mem_address and mem_data_in hold their last driven values.
- WMEM: 1 cycle with mem_write_enable=1, mem_address=addr, mem_data_in=data. Then IDLE.
- LOAD:
  - RD for RD_LAT cycles with mem_read_enable=1, mem_address=addr.
  - Then RWB for 1 cycle with mem_read_enable=1, mem_address held, reg_write_enable=1, reg_address1=rd. Then IDLE.
- RMEM:
  - RD for RD_LAT cycles with mem_read_enable=1, mem_address=addr.
  - rsp_data <= mem_data_out on the edge ending the last RD cycle. Then IDLE.
  - rsp_data holds until the next RMEM completes.
- ADD/MUL:
  - EXEC for EXEC_LAT cycles with reg_address1=ra, reg_address2=rb, alu_op=00 (ADD) or 01 (MUL).
  - Then WB for 1 cycle with reg_write_enable=1, reg_address1=rd, reg_address2 and alu_op held. Then IDLE.
- Illegal op:
  - Accepted and dropped; no enable ever asserts.
  - done=1 and err=1 in the following cycle.
- Latency counter: a 4-bit down-counter is loaded with RD_LAT-1 or EXEC_LAT-1 on entry. The state advances when it reads 0.
- done:
  - done=1 for exactly the first IDLE cycle after any command's final control cycle.
  - err=0 with done except for illegal ops.
  - cmd_ready is also 1 in that cycle, so back-to-back commands run with no bubble beyond that single cycle.
- Enable exclusivity:
  - mem_write_enable is never high together with mem_read_enable.
  - reg_write_enable is high only in RWB/WB.
- Reset mid-operation:
  - Immediate asynchronous return to IDLE with all outputs 0.
  - The in-flight command is lost and no done is produced.
- rd == ra or rd == rb is legal; the sequencer applies no hazard logic.

Test Plan:
- WMEM addr=0x001 data=0x0000000a, then addr=0x005 data=0x00000005 -> each gives a single mem_write_enable cycle with the correct address/data, and done one cycle later.
- LOAD rd=0 addr=0x001 (RD_LAT=1) -> read enable held 2 cycles, reg_write_enable=1 with reg_address1=00 in cycle 2, done in cycle 3. Then RMEM addr=0x001 -> rsp_data=0x0000000a.
- ADD ra=0 rb=1 rd=3, then MUL ra=2 rb=3 rd=3 issued back-to-back with cmd_valid held -> alu_op 00 then 01, and WB drives reg_address1=11 both times. Second cmd_ready/accept happens on the done cycle.
- cmd_op=111 -> no enables, done=1 and err=1 next cycle. A following valid ADD gives err=0.
- RD_LAT=3, EXEC_LAT=2 build -> LOAD spends 3 RD + 1 RWB cycles, ADD spends 2 EXEC + 1 WB cycles, cmd_ready=0 throughout.
- reset=0 asserted during EXEC of MUL -> all outputs 0 asynchronously, no done. After release, cmd_ready=1 and a new WMEM completes normally.
